// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single borrow flip-flop replaces the ripple chain; start/busy/done handshake.
module serial_subtractor_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             brw_nxt;
    logic             abit;
    logic             bbit;
    logic             dbit;
    logic             last;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Per-bit full-subtract cell; the partial result lives in acc until the last bit.
    always_comb begin
        accept  = start && (state != SHIFT);
        last    = (cnt == CW'(WIDTH - 1));
        abit    = areg[cnt];
        bbit    = breg[cnt];
        dbit    = abit ^ bbit ^ brw;
        brw_nxt = (~abit & bbit) | (~abit & brw) | (bbit & brw);
        acc_nxt = acc;
        acc_nxt[cnt] = dbit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            areg <= '0;
            breg <= '0;
            acc  <= '0;
            cnt  <= '0;
            brw  <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            areg <= a;
            breg <= b;
            brw  <= bin;
            cnt  <= '0;
            acc  <= '0;
        end else if (state == SHIFT) begin
            acc <= acc_nxt;
            brw <= brw_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                diff <= acc_nxt;
                bout <= brw_nxt;
                zero <= (acc_nxt == '0);
                ovf  <= (areg[WIDTH-1] != breg[WIDTH-1]) && (acc_nxt[WIDTH-1] != areg[WIDTH-1]);
            end
        end
    end

endmodule

// File: doc/serial_subtractor_8bit.md
Name: serial_subtractor_8bit

Overview:
Bit-serial two's-complement subtractor computing diff = a - b - bin, one bit per clock, LSB first. It is the subtract-direction companion to the team's ripple-carry adder. It reuses the same per-bit full-subtract equations but holds a single borrow flip-flop instead of chaining eight cells, trading latency for area. A start/busy/done handshake lets a sequencer or datapath controller launch an operation and collect the result and flags.

Parameters:
WIDTH, 8, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when not busy
a  input  WIDTH  minuend; sampled on the accepted-start cycle only
b  input  WIDTH  subtrahend; sampled on the accepted-start cycle only
bin  input  1  borrow-in; sampled on the accepted-start cycle only
busy  output  1  high while the operation is shifting
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  result a - b - bin (mod 2^WIDTH)
bout  output  1  final borrow; 1 when a < b + bin, unsigned
zero  output  1  diff == 0
ovf  output  1  signed overflow of the subtraction

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; busy=0, done=0, diff=0, bout=0, zero=0, ovf=0; internal operand registers, bit counter and borrow FF cleared. Reset wins over every other input, including start.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 latches a, b and bin into operand and borrow registers, clears the counter, and moves to SHIFT. start=0 stays in IDLE. Result outputs hold their last values.
- SHIFT: busy=1. Each cycle, bit i = counter value:
  - d = a[i] ^ b[i] ^ brw
  - brw_next = (~a[i] & b[i]) | (~a[i] & brw) | (b[i] & brw)
  - d is written to result bit i, and the counter increments.
- SHIFT exit: after the cycle that processes bit WIDTH-1, the state moves to DONE. Exactly WIDTH cycles are spent in SHIFT.
- start during SHIFT: ignored. The operand registers are not disturbed, even if the a/b inputs change.
- DONE: done=1 for exactly one cycle, busy=0.
  - diff holds the full result.
  - bout = final borrow.
  - zero = (diff == 0).
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]), using the latched operands.
  - bin does not enter the ovf formula except through diff.
- DONE exit: next state is IDLE. If start=1 in the DONE cycle, it is accepted, operands are latched, and the next state is SHIFT, allowing back-to-back operations.
- Latency: accepted start at edge N gives done=1 in the cycle after edge N+WIDTH. With WIDTH=8 the result is visible 9 cycles after the start edge, and one operation completes every WIDTH+1 cycles at full throughput.
- Output hold: diff, bout, zero and ovf are updated only on entry to DONE and are stable at all other times. Intermediate partial results stay in an internal shift register and are not visible on diff.
- Wrap-around: the arithmetic is modulo 2^WIDTH, and no saturation is applied.
- Reset mid-operation (rst during SHIFT): the block aborts to IDLE with all outputs zero. No done pulse is produced for the aborted operation.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then idle 5 cycles with start=0 -> busy=0, done=0, diff=0x00, bout=0, zero=0, ovf=0 throughout.
- Basic subtract: a=0x35, b=0x12, bin=0, start pulse -> busy high 8 cycles; done pulse 9 cycles after start; diff=0x23, bout=0, zero=0, ovf=0.
- Borrow and zero cases:
  - a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1, ovf=0.
  - a=0x05, b=0x04, bin=1 -> diff=0x00, zero=1, bout=0.
- Signed overflow:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
- Handshake edges:
  - start held high across an operation, with a/b changed mid-SHIFT -> result uses the originally latched operands.
  - start=1 in the DONE cycle with a=0xFF, b=0xFF -> second done exactly 9 cycles later, diff=0x00, zero=1.
- Reset mid-op: start with a=0x35, b=0x12, assert rst on the 4th SHIFT cycle -> no done pulse, all outputs 0. A new start afterwards completes normally with the correct result.
